uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the UART RX datapath. Detects the start bit on the serial line,
//  times mid-bit sampling from an oversampling baud tick, and drives the SIPO shift register
//  (shift_bit / RX_data pins). Checks optional parity and the stop bit, then flags frame
//  completion or error to the receiver top level.
// PARAMETERS
//  WIDTH      8   data bits per frame; equals SIPO WIDTH
//  OVERSAMPLE 16  baud_tick pulses per bit period; even, >= 4
//  PARITY_EN  0   1 = one parity bit follows the data bits
//  PARITY_ODD 0   1 = odd parity, 0 = even; ignored when PARITY_EN = 0
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  baud_tick  in   1  1-clk pulse at OVERSAMPLE x baud rate
//  rx_in      in   1  raw serial line, asynchronous, idle high
//  shift_bit  out  1  to SIPO shift_bit; 1-clk pulse per data bit
//  rx_bit     out  1  to SIPO RX_data; sampled data bit, valid while shift_bit = 1
//  rx_done    out  1  1-clk pulse: frame received with a valid stop bit
//  frame_err  out  1  1-clk pulse: stop bit sampled low
//  parity_err out  1  1-clk pulse with rx_done/frame_err: parity mismatch
//  busy       out  1  1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state = IDLE. All outputs, tick_cnt, bit_cnt and the parity accumulator = 0.
//    Both synchroniser flops = 1. Reset mid-frame abandons the frame; no pulse is emitted.
//  - rx_in passes through a 2-flop synchroniser to rx_s (2 clk latency). All decisions use rx_s.
//  - tick_cnt has width $clog2(OVERSAMPLE). It increments only on baud_tick and clears on each
//    state entry. With no baud_tick, the FSM is frozen.
//  - FSM. Every transition below is evaluated only on a cycle with baud_tick = 1:
//    IDLE:  rx_s = 0 -> START.
//    START: at tick_cnt = OVERSAMPLE/2-1, sample rx_s.
//           rx_s = 1 (glitch) -> IDLE, no outputs.
//           rx_s = 0 -> DATA, with bit_cnt = 0 and parity accumulator = 0.
//    DATA:  at tick_cnt = OVERSAMPLE-1 (mid-bit), sample rx_s. Register shift_bit = 1 and
//           rx_bit = rx_s for exactly the next clk cycle. XOR rx_s into the accumulator and
//           clear tick_cnt. After bit_cnt = WIDTH-1 -> PARITY if PARITY_EN, else STOP;
//           otherwise bit_cnt++.
//    PARITY: at tick_cnt = OVERSAMPLE-1, store par_bad = (acc ^ rx_s ^ PARITY_ODD) != 0 -> STOP.
//    STOP:  at tick_cnt = OVERSAMPLE-1, sample rx_s.
//           rx_s = 1 -> pulse rx_done -> IDLE.
//           rx_s = 0 -> pulse frame_err -> WAIT_IDLE.
//           In both cases parity_err = par_bad & PARITY_EN, coincident with the pulse.
//    WAIT_IDLE: stay until rx_s = 1 on a tick -> IDLE. A held-low line (break) never re-triggers.
//  - Data is sent LSB first. The SIPO shifts right, so after WIDTH pulses the byte is aligned.
//    rx_done fires OVERSAMPLE or more ticks after the last shift_bit, so SIPO data_out is
//    already stable when rx_done = 1.
//  - rx_done and frame_err are mutually exclusive. shift_bit never asserts outside DATA.
//  - Back-to-back frames: IDLE is entered at mid-stop-bit, so a start edge immediately after
//    the stop bit is detected.
//  - rx_bit holds its last value between pulses; it is don't-care while shift_bit = 0.
// TESTING (OVERSAMPLE = 16, bit period = 16 ticks unless noted)
//  1. PARITY_EN = 0, frame 0xA5.
//     -> 8 shift_bit pulses, rx_bit = 1,0,1,0,0,1,0,1; one rx_done; SIPO data_out = 0xA5;
//        frame_err = parity_err = 0.
//  2. rx_in low for 4 ticks, then high.
//     -> no shift_bit; busy drops at tick 8; FSM back in IDLE; no pulses.
//  3. rx_in held low for 12 bit periods, then high; then frame 0x3C.
//     -> frame_err pulse, no rx_done, FSM in WAIT_IDLE until the line goes high;
//        then rx_done with data_out = 0x3C.
//  4. PARITY_EN = 1, even parity, 0x07.
//     -> parity bit 1: rx_done, parity_err = 0.
//     -> parity bit 0: rx_done and parity_err in the same cycle.
//  5. rst pulsed low during data bit 4 of 0xFF, then frame 0x81.
//     -> all outputs 0 immediately; no pulse for the aborted frame; 0x81 received cleanly.
//  6. Frames 0x55 then 0xAA back-to-back (stop bit directly followed by start bit).
//     -> two rx_done pulses, data_out 0x55 then 0xAA, 16 shift_bit pulses in total.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving an external SIPO shift register
//   clk        system clock
//   rst        asynchronous reset, active-low
//   baud_tick  1-clk pulse at OVERSAMPLE x baud rate
//   rx_in      raw serial line, idle high
//   shift_bit  1-clk pulse per received data bit (to SIPO shift_bit)
//   rx_bit     sampled data bit, valid while shift_bit = 1 (to SIPO RX_data)
//   rx_done    1-clk pulse: frame received with valid stop bit
//   frame_err  1-clk pulse: stop bit sampled low
//   parity_err 1-clk pulse alongside rx_done/frame_err on parity mismatch
//   busy       high whenever the FSM is not idle
module uart_rx_ctrl #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx_in,
    output logic shift_bit,
    output logic rx_bit,
    output logic rx_done,
    output logic frame_err,
    output logic parity_err,
    output logic busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t state, state_nxt;
    logic rx_q, rx_s;
    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] bit_cnt;
    logic acc, par_bad;
    logic at_half, at_full;
    logic shift_d, done_d, ferr_d, perr_d, clr_tick;

    assign at_half = baud_tick && tick_cnt == T_HALF;
    assign at_full = baud_tick && tick_cnt == T_FULL;
    assign busy    = state != IDLE;

    // Two-flop synchroniser, reset to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx_in;
            rx_s <= rx_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // All transitions are qualified by baud_tick, so the FSM freezes without ticks
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (baud_tick && !rx_s) state_nxt = START;
            START:     if (at_half) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (at_full && bit_cnt == B_LAST) state_nxt = PARITY_EN != 0 ? PARITY : STOP;
            PARITY:    if (at_full) state_nxt = STOP;
            STOP:      if (at_full) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (baud_tick && rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_d  = state == DATA && at_full;
        done_d   = state == STOP && at_full && rx_s;
        ferr_d   = state == STOP && at_full && !rx_s;
        perr_d   = state == STOP && at_full && par_bad && PARITY_EN != 0;
        clr_tick = state_nxt != state || shift_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_bit  <= 1'b0;
            rx_bit     <= 1'b0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            par_bad    <= 1'b0;
        end else begin
            shift_bit  <= shift_d;
            rx_done    <= done_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            if (shift_d) rx_bit <= rx_s;
            if (baud_tick) tick_cnt <= clr_tick ? '0 : tick_cnt + 1'b1;
            if (state == START && at_half) begin
                bit_cnt <= '0;
                acc     <= 1'b0;
                par_bad <= 1'b0;
            end
            if (shift_d) begin
                acc     <= acc ^ rx_s;
                bit_cnt <= bit_cnt == B_LAST ? bit_cnt : bit_cnt + 1'b1;
            end
            if (state == PARITY && at_full) par_bad <= acc ^ rx_s ^ PARITY_ODD[0];
        end
    end
endmodule
